// File: rtl/pkt_defs.sv
// pkt_defs: shared word width, packet markers and arbiter state encoding.
package pkt_defs;
   localparam int WORD_W = 134;
   localparam logic [1:0] MARK_HEAD = 2'b01;
   localparam logic [1:0] MARK_BODY = 2'b11;
   localparam logic [1:0] MARK_TAIL = 2'b10;
   typedef enum logic {IDLE, SEND} state_e;
endpackage

// File: rtl/pkt_sfifo.sv
// pkt_sfifo: show-ahead synchronous FIFO; pushes to a full FIFO are dropped.
module pkt_sfifo #(
   parameter int WIDTH = 8,
   parameter int AW = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             full,
   output logic [AW:0]      count
);
   logic [WIDTH-1:0] mem_q [2**AW];
   logic [AW-1:0] wp_q, rp_q;
   logic do_push, do_pop;
   assign empty = count == '0;
   assign full = count[AW];
   assign do_push = push && !full;
   assign do_pop = pop && !empty;
   assign dout = mem_q[rp_q];
   always_ff @(posedge clk)
      if (do_push) mem_q[wp_q] <= din;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wp_q <= '0;
         rp_q <= '0;
         count <= '0;
      end else begin
         wp_q <= wp_q + AW'(do_push);
         rp_q <= rp_q + AW'(do_pop);
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
endmodule

// File: rtl/pkt_in_arb2.sv
// pkt_in_arb2: packet-granular round-robin merge of two buffered packet sources
// onto one um pktin interface; a packet is released only once its valid word is queued.
module pkt_in_arb2 import pkt_defs::*; #(
   parameter int DATA_AW = 8,
   parameter int VALID_AW = 4,
   parameter int PKT_MAX_WORDS = 128
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in0_data_wr,
   input  logic [WORD_W-1:0] in0_data,
   input  logic              in0_data_valid_wr,
   input  logic              in0_data_valid,
   output logic              in0_ready,
   input  logic              in1_data_wr,
   input  logic [WORD_W-1:0] in1_data,
   input  logic              in1_data_valid_wr,
   input  logic              in1_data_valid,
   output logic              in1_ready,
   output logic              out_data_wr,
   output logic [WORD_W-1:0] out_data,
   output logic              out_data_valid_wr,
   output logic              out_data_valid,
   input  logic              out_ready,
   output logic [1:0]        ovf_err
);
   localparam logic [DATA_AW:0] D_THR = (DATA_AW+1)'(2**DATA_AW - PKT_MAX_WORDS);
   logic [1:0] d_push, v_push, d_pop, v_pop, d_empty, d_full, v_empty, v_full;
   logic [1:0] v_in, v_out, avail, ready_q, ready_d, ovf_q;
   logic [1:0][WORD_W-1:0] d_in, d_out;
   logic [1:0][DATA_AW:0] d_cnt;
   logic [1:0][VALID_AW:0] v_cnt;
   state_e state_q, state_d;
   logic gnt_q, gnt_d, rr_q, rr_d, tail;
   logic owr_q, owr_d, ovwr_q, ovwr_d, ov_q, ov_d;
   logic [WORD_W-1:0] odata_q, odata_d;
   assign d_push = {in1_data_wr, in0_data_wr};
   assign v_push = {in1_data_valid_wr, in0_data_valid_wr};
   assign d_in = {in1_data, in0_data};
   assign v_in = {in1_data_valid, in0_data_valid};
   for (genvar i = 0; i < 2; i++) begin : g_in
      pkt_sfifo #(.WIDTH(WORD_W), .AW(DATA_AW)) u_data (
         .clk, .rst_n, .push(d_push[i]), .pop(d_pop[i]), .din(d_in[i]), .dout(d_out[i]),
         .empty(d_empty[i]), .full(d_full[i]), .count(d_cnt[i]));
      pkt_sfifo #(.WIDTH(1), .AW(VALID_AW)) u_valid (
         .clk, .rst_n, .push(v_push[i]), .pop(v_pop[i]), .din(v_in[i]), .dout(v_out[i]),
         .empty(v_empty[i]), .full(v_full[i]), .count(v_cnt[i]));
      assign ready_d[i] = (d_cnt[i] <= D_THR) && !v_cnt[i][VALID_AW];
   end
   // a queued valid bit implies its whole packet already sits in the data FIFO
   assign avail = ~v_empty;
   assign tail = d_out[gnt_q][WORD_W-1 -: 2] == MARK_TAIL;
   always_comb begin
      state_d = state_q;
      gnt_d = gnt_q;
      rr_d = rr_q;
      d_pop = '0;
      v_pop = '0;
      owr_d = 1'b0;
      odata_d = '0;
      ovwr_d = 1'b0;
      ov_d = 1'b0;
      if (state_q == IDLE) begin
         if (out_ready && |avail) begin
            gnt_d = &avail ? !rr_q : avail[1];
            rr_d = gnt_d;
            state_d = SEND;
         end
      end else if (!d_empty[gnt_q]) begin
         d_pop[gnt_q] = 1'b1;
         owr_d = 1'b1;
         odata_d = d_out[gnt_q];
         if (tail) begin
            v_pop[gnt_q] = 1'b1;
            ovwr_d = 1'b1;
            ov_d = v_out[gnt_q];
            state_d = IDLE;
         end
      end
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q <= IDLE;
         gnt_q <= 1'b0;
         rr_q <= 1'b1;
         ready_q <= '0;
         ovf_q <= '0;
         owr_q <= 1'b0;
         odata_q <= '0;
         ovwr_q <= 1'b0;
         ov_q <= 1'b0;
      end else begin
         state_q <= state_d;
         gnt_q <= gnt_d;
         rr_q <= rr_d;
         ready_q <= ready_d;
         ovf_q <= ovf_q | (d_push & d_full) | (v_push & v_full);
         owr_q <= owr_d;
         odata_q <= odata_d;
         ovwr_q <= ovwr_d;
         ov_q <= ov_d;
      end
   assign in0_ready = ready_q[0];
   assign in1_ready = ready_q[1];
   assign out_data_wr = owr_q;
   assign out_data = odata_q;
   assign out_data_valid_wr = ovwr_q;
   assign out_data_valid = ov_q;
   assign ovf_err = ovf_q;
endmodule

// File: tb/tb_pkt_in_arb2.sv
// tb_pkt_in_arb2: directed self-checking bench for the two-input packet arbiter.
module tb_pkt_in_arb2;
   import pkt_defs::*;
   logic clk = 1'b0, rst_n;
   logic in0_data_wr, in0_data_valid_wr, in0_data_valid, in0_ready;
   logic in1_data_wr, in1_data_valid_wr, in1_data_valid, in1_ready;
   logic [133:0] in0_data, in1_data, out_data;
   logic out_data_wr, out_data_valid_wr, out_data_valid, out_ready;
   logic [1:0] ovf_err;
   int n_tests = 0, n_fail = 0;

   pkt_in_arb2 dut (
      .clk(clk), .rst_n(rst_n),
      .in0_data_wr(in0_data_wr), .in0_data(in0_data), .in0_data_valid_wr(in0_data_valid_wr),
      .in0_data_valid(in0_data_valid), .in0_ready(in0_ready),
      .in1_data_wr(in1_data_wr), .in1_data(in1_data), .in1_data_valid_wr(in1_data_valid_wr),
      .in1_data_valid(in1_data_valid), .in1_ready(in1_ready),
      .out_data_wr(out_data_wr), .out_data(out_data), .out_data_valid_wr(out_data_valid_wr),
      .out_data_valid(out_data_valid), .out_ready(out_ready), .ovf_err(ovf_err));

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "watchdog");
   end

   function automatic logic [133:0] mkw(input int tag, input int k, input int len);
      logic [1:0] m;
      m = (k == 0) ? MARK_HEAD : (k == len - 1) ? MARK_TAIL : MARK_BODY;
      return {m, 100'(0), 16'(tag), 16'(k)};
   endfunction

   task automatic chk(input string name, input logic [133:0] obs, input logic [133:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", name, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic clear_in();
      in0_data_wr = 0; in0_data = '0; in0_data_valid_wr = 0; in0_data_valid = 0;
      in1_data_wr = 0; in1_data = '0; in1_data_valid_wr = 0; in1_data_valid = 0;
   endtask

   task automatic push(input bit e0, input bit e1, input int t0, input int t1, input int len,
                       input bit v0, input bit v1);
      for (int k = 0; k < len; k++) begin
         in0_data_wr = e0; in0_data = e0 ? mkw(t0, k, len) : '0;
         in0_data_valid_wr = e0 && (k == len - 1); in0_data_valid = v0;
         in1_data_wr = e1; in1_data = e1 ? mkw(t1, k, len) : '0;
         in1_data_valid_wr = e1 && (k == len - 1); in1_data_valid = v1;
         cyc();
      end
      clear_in();
   endtask

   task automatic expect_idle(input int n);
      for (int k = 0; k < n; k++) begin
         cyc();
         chk("idle_wr", 134'(out_data_wr), 134'(0));
         chk("idle_data", out_data, '0);
         chk("idle_vwr", 134'(out_data_valid_wr), 134'(0));
      end
   endtask

   task automatic expect_pkt(input int tag, input int len, input bit v, input int drop, input int n);
      for (int k = 0; k < n; k++) begin
         cyc();
         chk($sformatf("t%0d_w%0d_wr", tag, k), 134'(out_data_wr), 134'(1));
         chk($sformatf("t%0d_w%0d_data", tag, k), out_data, mkw(tag, k, len));
         chk($sformatf("t%0d_w%0d_vwr", tag, k), 134'(out_data_valid_wr), 134'(k == len - 1));
         if (k == len - 1) chk($sformatf("t%0d_valid", tag), 134'(out_data_valid), 134'(v));
         if (k == drop) out_ready = 0;
      end
   endtask

   task automatic chk_reset_outs(input string name);
      chk({name, "_owr"}, 134'(out_data_wr), 134'(0));
      chk({name, "_odata"}, out_data, '0);
      chk({name, "_ovwr"}, 134'(out_data_valid_wr), 134'(0));
      chk({name, "_ov"}, 134'(out_data_valid), 134'(0));
      chk({name, "_rdy"}, 134'({in1_ready, in0_ready}), 134'(0));
      chk({name, "_ovf"}, 134'(ovf_err), 134'(0));
   endtask

   initial begin
      rst_n = 0; out_ready = 0;
      clear_in();
      @(negedge clk);
      @(negedge clk);
      chk_reset_outs("rst0");
      rst_n = 1;
      #1 chk("rdy_lag", 134'({in1_ready, in0_ready}), 134'(0));
      cyc();
      chk("rdy_rise", 134'({in1_ready, in0_ready}), 134'(3));
      out_ready = 1;

      // single packet, in0, two edges from valid write to first word
      push(1, 0, 16'hff, 0, 6, 1, 0);
      expect_idle(1);
      expect_pkt(16'hff, 6, 1, -1, 6);
      expect_idle(2);

      // both inputs complete together: rr starts at 1 so in0 goes first, one bubble
      rst_n = 0;
      #1 rst_n = 1;
      push(1, 1, 20, 21, 6, 1, 1);
      expect_idle(1);
      expect_pkt(20, 6, 1, -1, 6);
      expect_idle(1);
      expect_pkt(21, 6, 1, -1, 6);
      expect_idle(1);

      // three queued per input: strict alternation, contiguous packets
      out_ready = 0;
      push(1, 1, 30, 31, 6, 1, 1);
      push(1, 1, 32, 33, 6, 1, 1);
      push(1, 1, 34, 35, 6, 1, 1);
      expect_idle(2);
      out_ready = 1;
      for (int p = 0; p < 6; p++) begin
         expect_idle(1);
         expect_pkt(30 + (p % 2) + 2 * (p / 2), 6, 1, -1, 6);
      end
      expect_idle(1);

      // out_ready low holds off the packet; dropping it mid-packet does not stall
      out_ready = 0;
      push(1, 0, 40, 0, 6, 1, 0);
      expect_idle(3);
      out_ready = 1;
      expect_idle(1);
      expect_pkt(40, 6, 1, 1, 6);
      expect_idle(2);
      out_ready = 1;

      // discarded packet still forwarded with valid = 0
      push(0, 1, 0, 50, 6, 0, 0);
      expect_idle(1);
      expect_pkt(50, 6, 0, -1, 6);
      expect_idle(1);
      chk("rdy_idle", 134'({in1_ready, in0_ready}), 134'(3));

      // fill in0: ready drops past 128 words, overflow beyond 256
      out_ready = 0;
      for (int i = 0; i < 260; i++) begin
         in0_data_wr = 1;
         in0_data = (i < 100) ? mkw(6, i, 100) : (i < 200) ? mkw(7, i - 100, 100) : mkw(8, 0, 2);
         in0_data_valid_wr = (i == 99) || (i == 199);
         in0_data_valid = 1;
         cyc();
         if (i == 128) chk("rdy_at128", 134'(in0_ready), 134'(1));
         if (i == 129) chk("rdy_at129", 134'(in0_ready), 134'(0));
         if (i == 255) chk("ovf_before", 134'(ovf_err), 134'(0));
         if (i == 256) chk("ovf_set", 134'(ovf_err), 134'(1));
      end
      clear_in();
      chk("in1_rdy_kept", 134'(in1_ready), 134'(1));
      out_ready = 1;
      expect_idle(1);
      expect_pkt(6, 100, 1, -1, 3);
      chk("ovf_sticky", 134'(ovf_err), 134'(1));
      rst_n = 0;
      #1 chk_reset_outs("rst_mid");
      @(negedge clk);
      rst_n = 1;
      cyc();
      chk("rdy_after_rst", 134'({in1_ready, in0_ready}), 134'(3));
      expect_idle(4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
